// File: rtl/sha_pkg.sv
// Shared definitions for the SHA stream arbiter slice.
//   - SHA algorithm codes carried in the hash-type TUSER slot
//   - TUSER slot geometry (slot n starts at bit TUSER_SLOT_OFFSET + n*TUSER_SLOT_WIDTH)
//   - arbiter FSM state encoding
package sha_pkg;

  localparam logic [1:0] SHA224 = 2'd0;
  localparam logic [1:0] SHA256 = 2'd1;
  localparam logic [1:0] SHA384 = 2'd2;
  localparam logic [1:0] SHA512 = 2'd3;

  localparam int TUSER_SLOT_OFFSET = 32;
  localparam int TUSER_SLOT_WIDTH  = 16;
  localparam int HASH_TUSER_SLOT   = 0;
  localparam int SRC_TUSER_SLOT    = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder.
//   req   in  N   request vector
//   start in  PW  index with highest priority (must be < N)
//   idx   out PW  first set request at or after start, wrapping
//   found out 1   any request set
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [PW-1:0] idx,
  output logic          found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (int'(start) + k) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = PW'(c);
      end
    end
  end

endmodule

// File: rtl/sha_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one SHA-2 pipeline among NUM_REQ
// AXI-Stream requesters. A grant is held from the first beat until the tlast
// handshake; the granted index is written into TUSER slot 1 so the digest can
// be routed back to its owner. Data path is a combinational pass-through.
//
// Ports:
//   axis_aclk, reset (sync, active-high)
//   s_axis_t{data,user,valid,last} in / s_axis_tready out : flattened requesters
//   m_axis_t{data,user,valid,last} out / m_axis_tready in : to hash core
//   busy      : high while a grant is held
//   grant_id  : current or last granted requester
//
// Build option: SHA_ARB_PRIO0_EN makes requester 0 strict-priority; the others
// round-robin among themselves and rr_ptr is untouched by requester-0 messages.
module sha_stream_arbiter
  import sha_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int ID_WIDTH           = 3
) (
  input  logic                                  axis_aclk,
  input  logic                                  reset,
  input  logic [NUM_REQ*C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_REQ*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_REQ-1:0]                    s_axis_tvalid,
  input  logic [NUM_REQ-1:0]                    s_axis_tlast,
  output logic [NUM_REQ-1:0]                    s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]         m_axis_tuser,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready,
  output logic                                  busy,
  output logic [ID_WIDTH-1:0]                   grant_id
);

  localparam int SRC_LSB = TUSER_SLOT_OFFSET + TUSER_SLOT_WIDTH * SRC_TUSER_SLOT;

  arb_state_t          state;
  logic [ID_WIDTH-1:0] rr_ptr;

  logic [NUM_REQ-1:0]  req_vec;
  logic [ID_WIDTH-1:0] rr_idx;
  logic                rr_found;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                pick_found;

  logic                sel_valid;
  logic                sel_last;
  logic [C_AXIS_TUSER_WIDTH-1:0] sel_user;

  always_comb begin
    req_vec = s_axis_tvalid;
`ifdef SHA_ARB_PRIO0_EN
    req_vec[0] = 1'b0;
`endif
  end

  rr_pick #(
    .N  (NUM_REQ),
    .PW (ID_WIDTH)
  ) u_rr_pick (
    .req   (req_vec),
    .start (rr_ptr),
    .idx   (rr_idx),
    .found (rr_found)
  );

  always_comb begin
    pick_idx   = rr_idx;
    pick_found = rr_found;
`ifdef SHA_ARB_PRIO0_EN
    if (s_axis_tvalid[0]) begin
      pick_idx   = '0;
      pick_found = 1'b1;
    end
`endif
  end

  // Slice select by grant_id; everything is gated by busy so nothing leaks
  // through while idle.
  always_comb begin
    m_axis_tdata  = '0;
    sel_user      = '0;
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        m_axis_tdata     = s_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
        sel_user         = s_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
        sel_valid        = s_axis_tvalid[i];
        sel_last         = s_axis_tlast[i];
        s_axis_tready[i] = busy & m_axis_tready;
      end
    end
    m_axis_tuser = sel_user;
    m_axis_tuser[SRC_LSB +: ID_WIDTH] = grant_id;
    m_axis_tvalid = busy & sel_valid;
    m_axis_tlast  = busy & sel_last;
  end

  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            busy     <= 1'b1;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
`ifdef SHA_ARB_PRIO0_EN
            if (grant_id != '0)
`endif
            rr_ptr <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sha_stream_arbiter.md
Name: sha_stream_arbiter

Overview:
- Packet-level round-robin arbiter sharing one SHA-2 hash pipeline, which feeds the digest stage, among NUM_REQ AXI-Stream requesters.
- Grant is held for a whole message, from first beat until the tlast handshake.
- The winning requester's index is written into a TUSER slot so the digest result can be routed back to its owner.

Parameters:
- NUM_REQ, 4, number of requester streams (2..8).
- C_AXIS_DATA_WIDTH, 512, tdata width on all ports.
- C_AXIS_TUSER_WIDTH, 128, tuser width on all ports.
- ID_WIDTH, 3, width of the source-ID field; must satisfy 2^ID_WIDTH >= NUM_REQ.

Ports:
- axis_aclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  NUM_REQ*C_AXIS_DATA_WIDTH  flattened requester data; requester i at slice i.
- s_axis_tuser  in  NUM_REQ*C_AXIS_TUSER_WIDTH  flattened requester tuser.
- s_axis_tvalid  in  NUM_REQ  per-requester valid.
- s_axis_tlast  in  NUM_REQ  per-requester last.
- s_axis_tready  out  NUM_REQ  per-requester ready.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  to hash core.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  to hash core, with source ID inserted.
- m_axis_tvalid  out  1  to hash core.
- m_axis_tlast  out  1  to hash core.
- m_axis_tready  in  1  from hash core.
- busy  out  1  high while a grant is held.
- grant_id  out  ID_WIDTH  index of the current or last granted requester.

Behaviour:
- FSM states: IDLE, GRANT.
- Registers: grant_id, rr_ptr (next requester with highest priority).
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, busy=0. All s_axis_tready=0 and m_axis_tvalid=0, because both are gated by state.
- IDLE:
  - If any s_axis_tvalid is set, pick the first set bit searching from rr_ptr upward with wrap-around.
  - Register it into grant_id and go to GRANT. Arbitration latency is 1 cycle; no beat transfers in IDLE.
- GRANT (combinational pass-through, no data registering):
  - m_axis_tdata/tlast/tvalid = slice grant_id.
  - s_axis_tready[grant_id] = m_axis_tready; all other ready bits are 0.
  - m_axis_tuser = s_axis_tuser[grant_id] with bits [48+ID_WIDTH-1:48] (TUSER slot 1: offset 32 + 16*1) replaced by grant_id.
  - Bits [33:32] (sha_type, slot 0) and all other tuser bits pass unchanged.
- On a handshake with tlast=1 in GRANT: rr_ptr = (grant_id+1) mod NUM_REQ, state=IDLE. This leaves a 1-cycle bubble between messages.
- The granted requester dropping tvalid mid-message does not release the grant; the arbiter waits indefinitely.
- Requests from other ports arriving during GRANT are ignored until IDLE.
- Single-beat message (tvalid and tlast on the first beat): one GRANT cycle when m_axis_tready=1, then IDLE.
- All requesters valid continuously: grants cycle 0,1,...,NUM_REQ-1,0; no starvation.
- busy = (state==GRANT). grant_id holds its value in IDLE.
- Reset asserted mid-message: returns to IDLE next edge. The partial message is truncated; the hash core is reset by the same signal.
- Slice i of s_axis_tvalid for i >= NUM_REQ does not exist. The ID field is zero-extended when NUM_REQ < 2^ID_WIDTH.

Optional Feature:
- Macro SHA_ARB_PRIO0_EN.
- Defined: requester 0 is strict-priority. In IDLE, if s_axis_tvalid[0] is set, it wins regardless of rr_ptr, and rr_ptr is not updated after its message. Requesters 1..NUM_REQ-1 round-robin among themselves when requester 0 is idle.
- Undefined: pure round-robin over all requesters, as described above.

Decomposition:
- Shared package sha_pkg: SHA224/256/384/512 2-bit codes, TUSER_SLOT_OFFSET=32, TUSER_SLOT_WIDTH=16, HASH_TUSER_SLOT=0, SRC_TUSER_SLOT=1. Also the FSM state encoding.
- One sub-module: rr_pick, a combinational rotating priority encoder. Inputs: req vector and start pointer. Outputs: index and found flag.

Test Plan:
- Reset, then s_axis_tvalid=4'b0100 with 3-beat message, m_axis_tready=1 -> grant_id=2 one cycle later; 3 beats out with tuser[50:48]=3'd2 and tlast on the 3rd; busy falls the cycle after; rr_ptr=3.
- All four valid with 1-beat messages, held continuously -> grant order 0,1,2,3,0; each grant separated by 1 IDLE cycle.
- Port 1 granted, m_axis_tready toggles 1,0,1,0 over a 2-beat message -> s_axis_tready[1] mirrors m_axis_tready, others stay 0; data stable while stalled.
- Port 3 granted, drops tvalid for 5 cycles mid-message while port 0 is valid -> grant stays 3, m_axis_tvalid=0 during the gap, and port 0 is served only after port 3's tlast.
- sha_type=2'b11 in s_axis_tuser[33:32] of port 1 -> m_axis_tuser[33:32]=2'b11 unchanged. Reset pulsed during beat 2 -> busy=0 and all ready bits 0 the next cycle.
- With SHA_ARB_PRIO0_EN defined, ports 0 and 2 always valid with 1-beat messages -> port 0 granted every arbitration and port 2 never; without the macro, 0 and 2 alternate.
